main_mem_responder: RTL and testbench
=====================================

# main_mem_responder

Block-transfer main-memory responder that sits on the memory side of the cache refill/write-back interface. It accepts one request at a time from the cache controller: a block read (refill) or a block write (write-back). It then moves a full block of `WORDS_PER_BLOCK` words over valid/ready beat channels. Storage is an internal block-organised array with a configurable access latency, standing in for off-chip memory.

## Interface
- `MEM_BLOCKS`, 4096: number of blocks stored
- `BLOCK_ADDR_WIDTH`, 12: block address width, `$clog2(MEM_BLOCKS)`
- `DATA_WIDTH`, 32: word width
- `OFFSET_WIDTH`, 4: word-in-block index width
- `WORDS_PER_BLOCK`, `1 << OFFSET_WIDTH`: beats per burst
- `READ_LATENCY`, 4: wait cycles before the first read beat; legal range 1..15
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: responder can accept a request
- `req_write` in 1: 1 = block write (write-back), 0 = block read (refill)
- `req_block_addr` in `BLOCK_ADDR_WIDTH`: block index ({tag, set} truncated)
- `req_offset` in `OFFSET_WIDTH`: critical word index (used only with the macro)
- `wdata_valid` in 1: write beat present
- `wdata_ready` out 1: write beat accepted
- `wdata` in `DATA_WIDTH`: write beat data
- `rdata_valid` out 1: read beat present
- `rdata_ready` in 1: cache accepts read beat
- `rdata` out `DATA_WIDTH`: read beat data
- `rdata_last` out 1: final beat of the read burst
- `wr_done` out 1: one-cycle pulse when a write burst completes

## Operation
- FSM states: `IDLE`, `WR_BURST`, `RD_WAIT`, `RD_BURST`.
- `IDLE`
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch `req_block_addr`, `req_write` and the start offset, and clear the beat counter.
  - Go to `WR_BURST` if write, else to `RD_WAIT` with the latency counter loaded to `READ_LATENCY`.
- `WR_BURST`
  - `wdata_ready`=1.
  - Each `wdata_valid` beat writes `wdata` to word (start offset + beat count) mod `WORDS_PER_BLOCK` of the latched block, then increments the beat count.
  - After beat `WORDS_PER_BLOCK-1`: pulse `wr_done` for the next cycle and return to `IDLE`.
  - A gap in `wdata_valid` stalls the burst with no timeout.
- `RD_WAIT`
  - Decrement the latency counter each cycle.
  - When it reaches 0, go to `RD_BURST` with the first word loaded into `rdata`.
- `RD_BURST`
  - `rdata_valid`=1; `rdata` holds the word at (start offset + beat count) mod `WORDS_PER_BLOCK`.
  - On `rdata_ready`, advance to the next word.
  - `rdata_last`=1 on beat `WORDS_PER_BLOCK-1`; its handshake returns the FSM to `IDLE`.
  - When `rdata_ready`=0, `rdata`, `rdata_valid` and `rdata_last` hold stable.
- Beat counter is `OFFSET_WIDTH+1` bits; word index wraps modulo `WORDS_PER_BLOCK`.
- Only one outstanding request. `req_ready`=0 in all non-`IDLE` states, so `req_valid` held during a burst is not accepted until the cycle after the burst ends.
- Write-after-read and read-after-write to the same block are ordered: a read issued after `wr_done` returns the written data.
- Storage contents are not reset and are X at power-up; the bench preloads them via hierarchical access or write bursts.

## Timing
- Reset values: `req_ready`=1, `wdata_ready`=0, `rdata_valid`=0, `rdata`=0, `rdata_last`=0, `wr_done`=0, FSM in `IDLE`.
- Reset asserted mid-burst aborts immediately. A write burst aborted this way leaves already-written words updated and the rest unchanged.
- Read latency: request accepted at edge N; first `rdata_valid` high from edge N+`READ_LATENCY`+1.
- With `rdata_ready` held high, a burst occupies `WORDS_PER_BLOCK` consecutive cycles.
- Write: the earliest first beat is accepted at edge N+1. With `wdata_valid` held high, `wr_done` is high during the cycle after edge N+`WORDS_PER_BLOCK`.
- `req_ready` returns high the cycle after the final beat handshake.

## Configuration
- `MAIN_MEM_CRITICAL_WORD_FIRST_EN`
  - Defined: a read burst starts at `req_offset` and wraps (for example, with `req_offset`=13: 13, 14, 15, 0, …, 12). A write burst starts at `req_offset` the same way.
  - Undefined: `req_offset` is ignored and all bursts start at word 0.
  - `rdata_last` always marks the `WORDS_PER_BLOCK`-th beat, regardless of start offset.

## Structure
- Shared package `cache_pkg` holds:
  - the `mem_state_t` enum;
  - the width constants `DATA_WIDTH`, `OFFSET_WIDTH`, `BLOCK_ADDR_WIDTH`, `WORDS_PER_BLOCK`;
  - a `mem_req_t` struct {write, block_addr, offset} shared with the cache controller.
- One sub-module, `main_mem_array`: synchronous single-port block/word array (write enable, block address, word index, wdata in; registered rdata out). It has no reset.

## Test plan
- Write burst to block 0x3A5, words 0x1000+i, `wdata_valid` always high → `wr_done` pulses exactly once, 16 cycles after acceptance. A following read of 0x3A5 returns 0x1000…0x100F, with `rdata_last` on the 16th beat.
- Read with `READ_LATENCY`=4, accepted at edge 10 → first `rdata_valid` at edge 15. With `rdata_ready` high, beats arrive on 16 consecutive cycles.
- `rdata_ready` toggled 1/0 every cycle during a read → no beat lost or duplicated, `rdata` stable while stalled, burst spans 31 cycles.
- With macro defined, read of a preloaded block with `req_offset`=13 → data order words 13, 14, 15, 0…12, and `rdata_last` on word 12. With macro undefined, the same stimulus → order 0…15.
- `req_valid` held high across a read burst, with a second write request queued → `req_ready` is 0 throughout the burst; the write is accepted the cycle after the `rdata_last` handshake.
- `reset` pulled low at beat 5 of a write burst to block 7 → all outputs return to reset values asynchronously. Words 0–4 of block 7 are updated and words 5–15 hold their prior values.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache/memory-side types and width constants for the refill/write-back path.
package cache_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int OFFSET_WIDTH     = 4;
  localparam int BLOCK_ADDR_WIDTH = 12;
  localparam int WORDS_PER_BLOCK  = 1 << OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic                        write;
    logic [BLOCK_ADDR_WIDTH-1:0] block_addr;
    logic [OFFSET_WIDTH-1:0]     offset;
  } mem_req_t;

  // One extra bit so a full block of beats can be counted without aliasing to zero.
  typedef logic [OFFSET_WIDTH:0] beat_t;

  function automatic logic [OFFSET_WIDTH-1:0] word_index(input logic [OFFSET_WIDTH-1:0] start,
                                                         input beat_t beat);
    return start + beat[OFFSET_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Single-port block/word storage with registered read data; contents are never reset.
module main_mem_array
  import cache_pkg::*;
#(
  parameter int MEM_BLOCKS = 4096
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [BLOCK_ADDR_WIDTH-1:0] block_addr,
  input  logic [OFFSET_WIDTH-1:0]     word_idx,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int DEPTH = MEM_BLOCKS * WORDS_PER_BLOCK;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BLOCK_ADDR_WIDTH+OFFSET_WIDTH-1:0] addr;

  assign addr = {block_addr, word_idx};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Block-transfer main-memory responder: one block read or write burst at a time.
// Optional MAIN_MEM_CRITICAL_WORD_FIRST_EN starts bursts at req_offset instead of word 0.
module main_mem_responder
  import cache_pkg::*;
#(
  parameter int MEM_BLOCKS   = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [BLOCK_ADDR_WIDTH-1:0]           req_block_addr,
  input  logic [OFFSET_WIDTH-1:0]               req_offset,
  input  logic                                  wdata_valid,
  output logic                                  wdata_ready,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  output logic                                  rdata_valid,
  input  logic                                  rdata_ready,
  output logic [DATA_WIDTH-1:0]                 rdata,
  output logic                                  rdata_last,
  output logic                                  wr_done,
  output logic [1:0]                            dbg_state,
  output logic [BLOCK_ADDR_WIDTH+OFFSET_WIDTH:0] dbg_req
);

  // Every channel transfers on a cycle where valid and ready are both high at the
  // rising edge; valid never depends on ready, and a stalled beat holds its payload.

  localparam beat_t      LAST_BEAT = beat_t'(WORDS_PER_BLOCK - 1);
  localparam beat_t      BEAT_ONE  = beat_t'(1);
  localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY);

  mem_state_t                state, state_n;
  mem_req_t                  req_q, req_n;
  beat_t                     beat_cnt, beat_n;
  logic [3:0]                lat_cnt, lat_n;
  logic                      wr_done_n;
  logic                      mem_we;
  logic [OFFSET_WIDTH-1:0]   mem_idx;
  logic [OFFSET_WIDTH-1:0]   start_off;
  logic [DATA_WIDTH-1:0]     arr_rdata;

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
  assign start_off = req_q.offset;
`else
  assign start_off = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_q    <= '0;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      wr_done  <= 1'b0;
    end else begin
      state    <= state_n;
      req_q    <= req_n;
      beat_cnt <= beat_n;
      lat_cnt  <= lat_n;
      wr_done  <= wr_done_n;
    end
  end

  always_comb begin
    state_n   = state;
    req_n     = req_q;
    beat_n    = beat_cnt;
    lat_n     = lat_cnt;
    wr_done_n = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = word_index(start_off, beat_cnt);
    case (state)
      IDLE: begin
        if (req_valid) begin
          req_n.write      = req_write;
          req_n.block_addr = req_block_addr;
          req_n.offset     = req_offset;
          beat_n           = '0;
          if (req_write) begin
            state_n = WR_BURST;
          end else begin
            state_n = RD_WAIT;
            lat_n   = LAT_LOAD;
          end
        end
      end
      WR_BURST: begin
        if (wdata_valid) begin
          mem_we = 1'b1;
          beat_n = beat_cnt + BEAT_ONE;
          if (beat_cnt == LAST_BEAT) begin
            wr_done_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      RD_WAIT: begin
        // The array is already addressed at the first word, so rdata is loaded on the exit edge.
        if (lat_cnt == 4'd0) begin
          state_n = RD_BURST;
        end else begin
          lat_n = lat_cnt - 4'd1;
        end
      end
      RD_BURST: begin
        if (rdata_ready) begin
          beat_n  = beat_cnt + BEAT_ONE;
          mem_idx = word_index(start_off, beat_cnt + BEAT_ONE);
          if (beat_cnt == LAST_BEAT) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  main_mem_array #(
    .MEM_BLOCKS(MEM_BLOCKS)
  ) u_array (
    .clk       (clk),
    .we        (mem_we),
    .block_addr(req_q.block_addr),
    .word_idx  (mem_idx),
    .wdata     (wdata),
    .rdata     (arr_rdata)
  );

  assign req_ready   = (state == IDLE);
  assign wdata_ready = (state == WR_BURST);
  assign rdata_valid = (state == RD_BURST);
  assign rdata       = rdata_valid ? arr_rdata : '0;
  assign rdata_last  = rdata_valid && (beat_cnt == LAST_BEAT);
  assign dbg_state   = state;
  assign dbg_req     = req_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: write/read bursts, latency, stalls, queued request, reset abort.
module tb_main_mem_responder;
  import cache_pkg::*;

  localparam int LAT = 4;

  logic                                   clk = 1'b0;
  logic                                   reset;
  logic                                   req_valid, req_write;
  logic                                   req_ready;
  logic [BLOCK_ADDR_WIDTH-1:0]            req_block_addr;
  logic [OFFSET_WIDTH-1:0]                req_offset;
  logic                                   wdata_valid, wdata_ready;
  logic [DATA_WIDTH-1:0]                  wdata;
  logic                                   rdata_valid, rdata_ready, rdata_last, wr_done;
  logic [DATA_WIDTH-1:0]                  rdata;
  logic [1:0]                             dbg_state;
  logic [BLOCK_ADDR_WIDTH+OFFSET_WIDTH:0] dbg_req;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  logic [DATA_WIDTH-1:0] exp_w [WORDS_PER_BLOCK];

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  main_mem_responder #(
    .MEM_BLOCKS  (4096),
    .READ_LATENCY(LAT)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_block_addr(req_block_addr),
    .req_offset    (req_offset),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .wdata         (wdata),
    .rdata_valid   (rdata_valid),
    .rdata_ready   (rdata_ready),
    .rdata         (rdata),
    .rdata_last    (rdata_last),
    .wr_done       (wr_done),
    .dbg_state     (dbg_state),
    .dbg_req       (dbg_req)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_beats(input logic [31:0] base);
    wdata_valid = 1'b1;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      wdata = base + 32'(i);
      check("wr_ready", {31'b0, wdata_ready}, 32'd1);
      check("wr_done_early", {31'b0, wr_done}, 32'd0);
      tick;
    end
    check("wr_done_pulse", {31'b0, wr_done}, 32'd1);
    check("wr_end_req_ready", {31'b0, req_ready}, 32'd1);
    wdata_valid = 1'b0;
    tick;
    check("wr_done_single", {31'b0, wr_done}, 32'd0);
  endtask

  task automatic write_block(input logic [11:0] addr, input logic [31:0] base);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_block_addr = addr;
    req_offset = 4'd0;
    tick;
    req_valid = 1'b0;
    check("wr_state", {30'b0, dbg_state}, 32'(WR_BURST));
    write_beats(base);
  endtask

  task automatic read_block(input logic [11:0] addr, input logic [3:0] off, input bit toggle,
                            input bit hold, input int exp_span);
    int acc_edge;
    int first_edge;
    int j;
    int cyc;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_block_addr = addr;
    req_offset = off;
    rdata_ready = 1'b1;
    tick;
    acc_edge = edge_cnt;
    if (hold) begin
      req_write = 1'b1;
      req_block_addr = 12'h0C1;
      req_offset = 4'd0;
    end else begin
      req_valid = 1'b0;
    end
    check("rd_req_ready_low", {31'b0, req_ready}, 32'd0);
    first_edge = -1;
    for (int k = 0; k < 40 && first_edge < 0; k++) begin
      if (rdata_valid) first_edge = edge_cnt;
      else tick;
    end
    check("rd_latency", 32'(first_edge - acc_edge), 32'(LAT + 1));
    j = 0;
    cyc = 0;
    while (j < WORDS_PER_BLOCK && cyc < 64) begin
      rdata_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      check("rd_valid", {31'b0, rdata_valid}, 32'd1);
      check("rd_data", rdata, exp_w[j]);
      check("rd_last", {31'b0, rdata_last}, {31'b0, (j == WORDS_PER_BLOCK - 1)});
      if (hold) check("rd_hold_req_ready", {31'b0, req_ready}, 32'd0);
      if (rdata_ready) j++;
      tick;
      cyc++;
    end
    rdata_ready = 1'b0;
    check("rd_span", 32'(cyc), 32'(exp_span));
    check("rd_end_valid", {31'b0, rdata_valid}, 32'd0);
    check("rd_end_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_block_addr = '0;
    req_offset = '0;
    wdata_valid = 1'b0;
    wdata = '0;
    rdata_ready = 1'b0;
    tick;
    tick;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
    check("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rdata_last", {31'b0, rdata_last}, 32'd0);
    check("rst_wr_done", {31'b0, wr_done}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'(IDLE));
    reset = 1'b1;
    tick;

    // Write-back to 0x3A5 then refill of the same block
    write_block(12'h3A5, 32'h1000);
    for (int i = 0; i < WORDS_PER_BLOCK; i++) exp_w[i] = 32'h1000 + 32'(i);
    read_block(12'h3A5, 4'd0, 1'b0, 1'b0, 16);

    // Preloaded block, ready toggling every cycle
    for (int w = 0; w < WORDS_PER_BLOCK; w++) u_dut.u_array.mem[12'h055 * 16 + w] = 32'hA500 + 32'(w);
    for (int i = 0; i < WORDS_PER_BLOCK; i++) exp_w[i] = 32'hA500 + 32'(i);
    read_block(12'h055, 4'd0, 1'b1, 1'b0, 31);

    // Critical-word offset 13
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
      exp_w[i] = 32'hA500 + 32'((13 + i) % 16);
`else
      exp_w[i] = 32'hA500 + 32'(i);
`endif
    end
    read_block(12'h055, 4'd13, 1'b0, 1'b0, 16);

    // Request held during a read burst; queued write accepted right after it
    for (int i = 0; i < WORDS_PER_BLOCK; i++) exp_w[i] = 32'h1000 + 32'(i);
    read_block(12'h3A5, 4'd0, 1'b0, 1'b1, 16);
    wdata_valid = 1'b1;
    wdata = 32'h2000;
    tick;
    req_valid = 1'b0;
    check("queued_wr_state", {30'b0, dbg_state}, 32'(WR_BURST));
    check("queued_wr_req_ready", {31'b0, req_ready}, 32'd0);
    write_beats(32'h2000);
    for (int i = 0; i < WORDS_PER_BLOCK; i++) exp_w[i] = 32'h2000 + 32'(i);
    read_block(12'h0C1, 4'd0, 1'b0, 1'b0, 16);

    // Reset at beat 5 of a write to block 7
    for (int w = 0; w < WORDS_PER_BLOCK; w++) u_dut.u_array.mem[7 * 16 + w] = 32'hDEAD0000 + 32'(w);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_block_addr = 12'h007;
    req_offset = 4'd0;
    tick;
    req_valid = 1'b0;
    wdata_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 32'h7000 + 32'(i);
      tick;
    end
    wdata = 32'h7005;
    #2;
    reset = 1'b0;
    #1;
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_wdata_ready", {31'b0, wdata_ready}, 32'd0);
    check("abort_state", {30'b0, dbg_state}, 32'(IDLE));
    check("abort_wr_done", {31'b0, wr_done}, 32'd0);
    tick;
    wdata_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    for (int i = 0; i < WORDS_PER_BLOCK; i++)
      exp_w[i] = (i < 5) ? 32'h7000 + 32'(i) : 32'hDEAD0000 + 32'(i);
    read_block(12'h007, 4'd0, 1'b0, 1'b0, 16);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
